// File: rtl/sprite_draw_scheduler.sv
// Frame-latched round-robin scheduler: each requesting sprite gets an erase
// pass then a move pass on the shared VGA plot port, pixels registered out.
module sprite_draw_scheduler #(
  parameter int N_SPRITES = 4,
  parameter int PIXELS    = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    frame_tick,
  input  logic [N_SPRITES-1:0]    req,
  input  logic [N_SPRITES-1:0]    dir_v,
  input  logic [N_SPRITES-1:0]    sprite_complete,
  input  logic [8*N_SPRITES-1:0]  sprite_x,
  input  logic [7*N_SPRITES-1:0]  sprite_y,
  input  logic [12*N_SPRITES-1:0] sprite_colour,
  output logic [N_SPRITES-1:0]    draw,
  output logic                    clear,
  output logic                    shift_h,
  output logic                    shift_v,
  output logic                    plot,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [11:0]             vga_colour,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic                    watchdog_err
);

  localparam int GW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int CW = $clog2(2*PIXELS + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(2*PIXELS - 1);

  typedef enum logic [2:0] {IDLE, ARB, ERASE, MOVE, DONE} state_t;

  state_t                        state, state_nxt;
  logic [N_SPRITES-1:0]          pending, dir_lat;
  logic [CW-1:0]                 pix_cnt;
  logic [GW-1:0]                 g, last_grant, rr_pick, cand;
  logic                          rr_found, active, pass_end, wd_hit;

  logic [N_SPRITES-1:0][7:0]     xs;
  logic [N_SPRITES-1:0][6:0]     ys;
  logic [N_SPRITES-1:0][11:0]    cs;

  assign xs = sprite_x;
  assign ys = sprite_y;
  assign cs = sprite_colour;

  // Rotating priority: first pending sprite after the last one served.
  always_comb begin
    rr_pick  = last_grant;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 1; i <= N_SPRITES; i++) begin
      cand = GW'((int'(last_grant) + i) % N_SPRITES);
      if (!rr_found && pending[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
  end

  // Ending on complete (not a fixed count) lets a misaligned pointer resync.
  assign pass_end = sprite_complete[g] && (pix_cnt != '0);
  assign wd_hit   = (pix_cnt == WD_LAST) && !pass_end;
  assign active   = (state == ERASE) || (state == MOVE);

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_draw
    assign draw[i] = active && (g == GW'(i));
  end

  always_comb begin
    clear      = (state == ERASE);
    shift_v    = (state == MOVE) && dir_lat[g];
    shift_h    = (state == MOVE) && !dir_lat[g];
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    overrun    = frame_tick && (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick) state_nxt = ARB;
      ARB:     state_nxt = rr_found ? ERASE : DONE;
      ERASE:   if (pass_end) state_nxt = MOVE;
               else if (wd_hit) state_nxt = ARB;
      MOVE:    if (pass_end || wd_hit) state_nxt = ARB;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      pending      <= '0;
      dir_lat      <= '0;
      pix_cnt      <= '0;
      g            <= '0;
      last_grant   <= GW'(N_SPRITES - 1);
      watchdog_err <= 1'b0;
      plot         <= 1'b0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (frame_tick) begin
          pending <= req;
          dir_lat <= dir_v;
        end
        ARB: begin
          pix_cnt <= '0;
          if (rr_found) g <= rr_pick;
        end
        ERASE, MOVE: begin
          if (pass_end) begin
            pix_cnt <= '0;
            if (state == MOVE) begin
              pending[g] <= 1'b0;
              last_grant <= g;
            end
          end else if (wd_hit) begin
            pix_cnt      <= '0;
            pending[g]   <= 1'b0;
            watchdog_err <= 1'b1;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      // Controllers update on negedge, so this edge sees the current pixel.
      plot <= |draw;
      if (|draw) begin
        vga_x      <= xs[g];
        vga_y      <= ys[g];
        vga_colour <= cs[g];
      end
    end
  end

endmodule

// File: doc/sprite_draw_scheduler.md
# sprite_draw_scheduler

Per-frame scheduler that shares the single VGA plot port among `N_SPRITES` 64-pixel sprite controllers (missiles, ship sprites). On each frame tick it latches which sprites need to move. It then serves them round-robin. For each granted sprite it runs an erase pass (`clear`) followed by a move pass (`shift_h` or `shift_v`), and muxes that sprite's pixel stream onto a registered VGA write bus. It sits between the game-logic FSM (requests, frame tick) and the VGA adapter.

## Interface
Parameters:
- `N_SPRITES`, 4: number of sprite controllers served; grant index width is `$clog2(N_SPRITES)`.
- `PIXELS`, 64: nominal pixels per pass; watchdog limit is `2*PIXELS` cycles.

Ports:
- `clk`  in  1  system clock; all scheduler state on posedge.
- `resetn`  in  1  reset, synchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse at frame start.
- `req`  in  N_SPRITES  sprite i wants a redraw this frame.
- `dir_v`  in  N_SPRITES  per sprite: 1 = vertical shift, 0 = horizontal.
- `sprite_complete`  in  N_SPRITES  each controller's `complete` output (pointer == 0).
- `sprite_x`  in  8*N_SPRITES  flattened `x_out`; sprite i at [8i+7:8i].
- `sprite_y`  in  7*N_SPRITES  flattened `y_out`.
- `sprite_colour`  in  12*N_SPRITES  flattened `colour_out`.
- `draw`  out  N_SPRITES  one-hot enable to the granted sprite; all zero otherwise.
- `clear`, `shift_h`, `shift_v`  out  1 each  pass mode, broadcast; at most one high, only while `draw` is nonzero.
- `plot`  out  1  VGA write enable, registered.
- `vga_x`  out  8, `vga_y`  out  7, `vga_colour`  out  12  registered pixel for the VGA adapter.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse when all latched requests are served.
- `overrun`  out  1  one-cycle pulse when `frame_tick` arrives while `busy`.
- `watchdog_err`  out  1  sticky until reset; a pass exceeded `2*PIXELS` cycles.

## Operation
- States: IDLE, ARB, ERASE, MOVE, DONE.
- IDLE: on `frame_tick`, latch `pending <= req` and `dir_lat <= dir_v`, then go to ARB.
- ARB: one cycle.
  - If `pending == 0`, go to DONE.
  - Otherwise grant `g` = the first set bit of `pending`, searching from `last_grant+1` upward and wrapping modulo `N_SPRITES`. Clear `pix_cnt`, go to ERASE.
- ERASE: `draw[g]=1`, `clear=1`.
  - The pass ends at the first posedge where `sprite_complete[g]==1` and `pix_cnt != 0`. That is cycle 64 for an aligned controller.
  - On the end cycle, `draw` is still asserted, `pix_cnt` clears, and the FSM goes to MOVE.
- MOVE: `draw[g]=1`, with `shift_v=dir_lat[g]` and `shift_h=~dir_lat[g]`.
  - Same end rule as ERASE.
  - On end: `pending[g] <= 0`, `last_grant <= g`, go to ARB.
- DONE: `frame_done=1` for one cycle, then IDLE.
- Watchdog: if `pix_cnt` reaches `2*PIXELS` in ERASE or MOVE:
  - set `watchdog_err`;
  - drop `pending[g]`;
  - go to ARB.
- Ending passes on `complete` rather than a fixed count is what lets a controller whose pointer was left mid-pass (for example by a scheduler reset) realign after one short pass.
- Pixel path:
  - Every cycle: `plot <= |draw`, `vga_x <= sprite_x[g]`, `vga_y <= sprite_y[g]`, `vga_colour <= sprite_colour[g]`.
  - Controllers update their outputs on negedge, so the posedge sample captures the pixel produced during the current draw cycle.
  - `vga_*` hold their value when `plot=0`.
- `frame_tick` while `busy`: ignored for scheduling, `overrun` pulses.
- `req` and `dir_v` changes mid-frame have no effect until the next latch.

## Timing
- Reset (`resetn==0` at posedge) sets:
  - state IDLE; `pending`, `dir_lat`, `pix_cnt` = 0;
  - `last_grant = N_SPRITES-1`, so sprite 0 is favoured first;
  - `draw`, `clear`, `shift_h`, `shift_v`, `plot`, `busy`, `frame_done`, `overrun`, `watchdog_err` = 0;
  - `vga_x`, `vga_y`, `vga_colour` = 0.
  - Reset mid-pass takes effect at that edge; `draw` drops immediately.
- Latency:
  - `frame_tick` at cycle T gives ARB at T+1 and the first `draw` at T+2.
  - `plot` lags `draw` by exactly 1 cycle.
- Per aligned sprite: 1 ARB + 64 ERASE + 64 MOVE = 129 cycles.
- Frame with k requests: `frame_done` at T + 2 + 129k.
- `draw`, `clear`, `shift_*` are combinational from state and `g`, and are glitch-free at posedge.

## Test plan
- Single sprite: `req=4'b0001`, `dir_v=0`, complete models a 64-cycle pointer.
  - `draw[0]` high for 128 cycles: `clear` for 64, then `shift_h` for 64.
  - `plot` count = 128; `frame_done` at T+131.
- Round-robin: `req=4'b1011` on two frames.
  - Grant order is 0, 1, 3 on frame 1; 0, 1, 3 on frame 2, because `last_grant=3` wraps to 0.
  - With `req=4'b0110` after `last_grant=1`, the order is 2 then 1.
- Misaligned controller: sprite 2's pointer preset to 40.
  - ERASE ends after 24 cycles; MOVE takes 64; `watchdog_err` stays 0.
- Stuck controller: `sprite_complete[1]` tied 0.
  - After 128 cycles, `watchdog_err=1` and sprite 1 is dropped.
  - The remaining sprites are still served, and `frame_done` pulses.
- Overrun and empty frame:
  - `frame_tick` during a MOVE gives an `overrun` pulse and no restart.
  - `req=0` gives `frame_done` at T+2 with no `plot`.
- Reset mid-ERASE at cycle 30: the next cycle has all outputs zero and state IDLE. A following frame completes normally.
